// File: rtl/d_flip_flop_pkg.sv
// Shared defaults and data type for the enabled D flip-flop register.
// Blocks that import this package get a data word sized to the default width.
package d_flip_flop_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VAL = '0;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_bit.sv
// Single-bit edge-triggered storage cell with clock enable.
// Asynchronous active-low reset loads the per-bit reset value.
module d_flip_flop_bit #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic d,
  output logic q
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its inputs; reset is in the
  // sensitivity list so it acts without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule : d_flip_flop_bit

// File: rtl/d_flip_flop_en.sv
// Parameterisable enabled D register with complement output and change flag.
// Optional registered parity output when D_FLIP_FLOP_PARITY_EN is defined.
module d_flip_flop_en
  import d_flip_flop_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic             changed
`ifdef D_FLIP_FLOP_PARITY_EN
  ,
  output logic             Q_parity
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_flip_flop_bit #(
      .RESET_VAL(RESET_VAL[i])
    ) u_bit (
      .clock  (clock),
      .reset_n(reset_n),
      .enable (enable),
      .d      (D[i]),
      .q      (Q[i])
    );
  end

  assign Q_n = ~Q;

  // Compares against the pre-edge Q, so the flag marks a capture that altered Q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      changed <= 1'b0;
    end else begin
      changed <= enable && (D != Q);
    end
  end

`ifdef D_FLIP_FLOP_PARITY_EN
  // Parity of the incoming word is registered so it tracks Q with no extra lag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Q_parity <= ^RESET_VAL;
    end else if (enable) begin
      Q_parity <= ^D;
    end
  end
`endif

endmodule : d_flip_flop_en

// File: tb/tb_d_flip_flop_en.sv
// Directed self-checking bench for d_flip_flop_en: a 1-bit instance with
// default reset value and an 8-bit instance reset to 8'hA5.
module tb_d_flip_flop_en;
  import d_flip_flop_pkg::*;

  logic clock;
  int   checks = 0;
  int   errors = 0;

  // 1-bit instance
  logic  reset_n_a;
  logic  enable_a;
  data_t d_a;
  data_t q_a;
  data_t q_n_a;
  logic  changed_a;

  // 8-bit instance
  logic       reset_n_b;
  logic       enable_b;
  logic [7:0] d_b;
  logic [7:0] q_b;
  logic [7:0] q_n_b;
  logic       changed_b;

`ifdef D_FLIP_FLOP_PARITY_EN
  logic parity_a;
  logic parity_b;
`endif

  d_flip_flop_en u_dut_a (
    .clock   (clock),
    .reset_n (reset_n_a),
    .enable  (enable_a),
    .D       (d_a),
    .Q       (q_a),
    .Q_n     (q_n_a),
    .changed (changed_a)
`ifdef D_FLIP_FLOP_PARITY_EN
    ,
    .Q_parity(parity_a)
`endif
  );

  d_flip_flop_en #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5)
  ) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n_b),
    .enable  (enable_b),
    .D       (d_b),
    .Q       (q_b),
    .Q_n     (q_n_b),
    .changed (changed_b)
`ifdef D_FLIP_FLOP_PARITY_EN
    ,
    .Q_parity(parity_b)
`endif
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n_a = 1'b0; enable_a = 1'b1; d_a = 1'b1;
    reset_n_b = 1'b0; enable_b = 1'b1; d_b = 8'hFF;
    #10;
    check("rst_q",   8'(q_a),     8'h00);
    check("rst_qn",  8'(q_n_a),   8'h01);
    check("rst_chg", 8'(changed_a), 8'h00);
    tick();
    check("rst_edge_q",   8'(q_a),       8'h00);
    check("rst_edge_chg", 8'(changed_a), 8'h00);
    tick();
    check("rst_edge2_q",  8'(q_a),       8'h00);
    check("rst_edge2_qn", 8'(q_n_a),     8'h01);

    // Release, capture a 1, then assert reset between edges.
    reset_n_a = 1'b1;
    tick();
    check("first_cap_q", 8'(q_a), 8'h01);
    #20 reset_n_a = 1'b0;
    #1;
    check("async_rst_q",   8'(q_a),       8'h00);
    check("async_rst_qn",  8'(q_n_a),     8'h01);
    check("async_rst_chg", 8'(changed_a), 8'h00);

    // Hold: enable low with D high.
    #5 reset_n_a = 1'b1; enable_a = 1'b0; d_a = 1'b1;
    tick();
    check("hold_q",   8'(q_a),       8'h00);
    check("hold_chg", 8'(changed_a), 8'h00);

    // Capture new value.
    enable_a = 1'b1; d_a = 1'b1;
    tick();
    check("cap_q",   8'(q_a),       8'h01);
    check("cap_qn",  8'(q_n_a),     8'h00);
    check("cap_chg", 8'(changed_a), 8'h01);
    tick();
    check("same_q",   8'(q_a),       8'h01);
    check("same_chg", 8'(changed_a), 8'h00);

    // New value 0, then disabled edge with D toggling in between.
    d_a = 1'b0;
    tick();
    check("new_q",   8'(q_a),       8'h00);
    check("new_qn",  8'(q_n_a),     8'h01);
    check("new_chg", 8'(changed_a), 8'h01);
    enable_a = 1'b0; d_a = 1'b1;
    #20 d_a = 1'b0;
    #20 d_a = 1'b1;
    tick();
    check("dis_q",   8'(q_a),       8'h00);
    check("dis_chg", 8'(changed_a), 8'h00);

    // Mid-operation reset pulse.
    enable_a = 1'b1; d_a = 1'b1;
    tick();
    check("pre_mid_q", 8'(q_a), 8'h01);
    #20 reset_n_a = 1'b0;
    #1;
    check("mid_rst_q",  8'(q_a),   8'h00);
    check("mid_rst_qn", 8'(q_n_a), 8'h01);
    #4 reset_n_a = 1'b1;
    tick();
    check("post_mid_q",   8'(q_a),       8'h01);
    check("post_mid_chg", 8'(changed_a), 8'h01);

    // 8-bit instance, still held in reset.
    check("w8_rst_q",   q_b,          8'hA5);
    check("w8_rst_qn",  q_n_b,        8'h5A);
    check("w8_rst_chg", 8'(changed_b), 8'h00);
`ifdef D_FLIP_FLOP_PARITY_EN
    check("w8_rst_par", 8'(parity_b), 8'h00);
    check("w1_par",     8'(parity_a), 8'h01);
`endif
    reset_n_b = 1'b1; enable_b = 1'b1; d_b = 8'h3C;
    tick();
    check("w8_cap_q",   q_b,           8'h3C);
    check("w8_cap_qn",  q_n_b,         8'hC3);
    check("w8_cap_chg", 8'(changed_b), 8'h01);
`ifdef D_FLIP_FLOP_PARITY_EN
    check("w8_cap_par", 8'(parity_b), 8'h00);
`endif
    d_b = 8'h01;
    tick();
    check("w8_01_q",   q_b,           8'h01);
    check("w8_01_chg", 8'(changed_b), 8'h01);
`ifdef D_FLIP_FLOP_PARITY_EN
    check("w8_01_par", 8'(parity_b), 8'h01);
`endif
    enable_b = 1'b0; d_b = 8'hFF;
    tick();
    check("w8_hold_q",   q_b,           8'h01);
    check("w8_hold_chg", 8'(changed_b), 8'h00);
`ifdef D_FLIP_FLOP_PARITY_EN
    check("w8_hold_par", 8'(parity_b), 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_d_flip_flop_en
